// File: rtl/data_table_ram_arb_if.sv
// Engine/RAM bundle for the hash-table data RAM arbiter.
// slave = arbiter side, master = engines plus RAM.
interface data_table_ram_arb_if #(
    parameter int CLIENT_CNT = 4,
    parameter int A_WIDTH    = 8,
    parameter int D_WIDTH    = 64
);
    logic [CLIENT_CNT-1:0]         rd_req_i;
    logic [CLIENT_CNT*A_WIDTH-1:0] rd_addr_i;
    logic [CLIENT_CNT-1:0]         rd_gnt_o;
    logic [D_WIDTH-1:0]            rd_data_o;
    logic [CLIENT_CNT-1:0]         rd_data_val_o;
    logic [CLIENT_CNT-1:0]         wr_req_i;
    logic [CLIENT_CNT*A_WIDTH-1:0] wr_addr_i;
    logic [CLIENT_CNT*D_WIDTH-1:0] wr_data_i;
    logic [CLIENT_CNT-1:0]         wr_gnt_o;
    logic [A_WIDTH-1:0]            ram_rd_addr_o;
    logic [D_WIDTH-1:0]            ram_rd_data_i;
    logic [A_WIDTH-1:0]            ram_wr_addr_o;
    logic [D_WIDTH-1:0]            ram_wr_data_o;
    logic                          ram_wr_en_o;

    modport slave (
        input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
        input  ram_rd_data_i,
        output rd_gnt_o, rd_data_o, rd_data_val_o, wr_gnt_o,
        output ram_rd_addr_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_en_o
    );

    modport master (
        output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
        output ram_rd_data_i,
        input  rd_gnt_o, rd_data_o, rd_data_val_o, wr_gnt_o,
        input  ram_rd_addr_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_en_o
    );
endinterface

// File: rtl/data_table_ram_arb.sv
// Registered read/write arbiter for the shared hash-table data RAM,
// with per-read client tags and write-to-read forwarding.
module data_table_ram_arb #(
    parameter int CLIENT_CNT  = 4,
    parameter int A_WIDTH     = 8,
    parameter int D_WIDTH     = 64,
    parameter int RAM_LATENCY = 2,
    parameter int RR_MODE     = 1
) (
    input logic                 clk_i,
    input logic                 rst_i,
    data_table_ram_arb_if.slave bus
);
    localparam int IW = (CLIENT_CNT > 1) ? $clog2(CLIENT_CNT) : 1;
    localparam int L  = RAM_LATENCY;

    typedef logic [CLIENT_CNT-1:0] vec_t;
    typedef logic [IW-1:0]         idx_t;

    typedef struct packed {
        logic               vld;
        idx_t               id;
        logic [A_WIDTH-1:0] addr;
        logic               fv;
        logic [D_WIDTH-1:0] fd;
    } tag_t;

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    function automatic vec_t pick(input vec_t req, input idx_t ptr);
        vec_t msk;
        vec_t hi;
        for (int k = 0; k < CLIENT_CNT; k++) begin
            msk[k] = (RR_MODE != 0) && (k >= int'(ptr));
        end
        hi = req & msk;
        if (hi != '0) return hi & (~hi + vec_t'(1));
        return req & (~req + vec_t'(1));
    endfunction

    function automatic idx_t enc(input vec_t g);
        idx_t r;
        r = '0;
        for (int k = 0; k < CLIENT_CNT; k++) begin
            if (g[k]) r = idx_t'(k);
        end
        return r;
    endfunction

    function automatic idx_t nxt_ptr(input vec_t g, input idx_t p);
        idx_t r;
        r = p;
        for (int k = 0; k < CLIENT_CNT; k++) begin
            if (g[k]) r = (k == CLIENT_CNT - 1) ? '0 : idx_t'(k + 1);
        end
        return r;
    endfunction

    idx_t               rd_ptr;
    idx_t               wr_ptr;
    vec_t               rd_gnt;
    vec_t               wr_gnt;
    logic               rd_any;
    logic               wr_any;
    logic [A_WIDTH-1:0] rd_addr;
    logic [A_WIDTH-1:0] wr_addr;
    logic [D_WIDTH-1:0] wr_data;
    logic               last_hit;
    logic [D_WIDTH-1:0] out_data;

    tag_t stg [0:L];
    tag_t nxt [0:L];

    vec_t               val_q;
    logic [D_WIDTH-1:0] data_q;
    logic               wen_q;
    logic [A_WIDTH-1:0] waddr_q;
    logic [D_WIDTH-1:0] wdata_q;

    assign rd_gnt = pick(bus.rd_req_i, rd_ptr);
    assign wr_gnt = pick(bus.wr_req_i, wr_ptr);
    assign rd_any = |rd_gnt;
    assign wr_any = |wr_gnt;

    always_comb begin
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int k = 0; k < CLIENT_CNT; k++) begin
            if (rd_gnt[k]) rd_addr = bus.rd_addr_i[k*A_WIDTH +: A_WIDTH];
            if (wr_gnt[k]) begin
                wr_addr = bus.wr_addr_i[k*A_WIDTH +: A_WIDTH];
                wr_data = bus.wr_data_i[k*D_WIDTH +: D_WIDTH];
            end
        end
    end

    // A write granted with a read to the same address is ordered first,
    // and later writes overwrite the captured data (youngest wins).
    always_comb begin
        for (int i = 0; i <= L; i++) nxt[i] = '0;
        nxt[0].vld  = rd_any;
        nxt[0].id   = enc(rd_gnt);
        nxt[0].addr = rd_addr;
        nxt[0].fv   = wr_any && (wr_addr == rd_addr);
        nxt[0].fd   = wr_data;
        for (int i = 1; i <= L; i++) begin
            nxt[i] = stg[i-1];
            if (wr_any && stg[i-1].vld && (stg[i-1].addr == wr_addr)) begin
                nxt[i].fv = 1'b1;
                nxt[i].fd = wr_data;
            end
        end
    end

    assign last_hit = wr_any && stg[L].vld && (stg[L].addr == wr_addr);

    always_comb begin
        out_data = bus.ram_rd_data_i;
        if (last_hit)        out_data = wr_data;
        else if (stg[L].fv)  out_data = stg[L].fd;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            val_q   <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            for (int i = 0; i <= L; i++) stg[i] <= '0;
        end else begin
            rd_ptr  <= nxt_ptr(rd_gnt, rd_ptr);
            wr_ptr  <= nxt_ptr(wr_gnt, wr_ptr);
            val_q   <= stg[L].vld ? (vec_t'(1) << stg[L].id) : '0;
            data_q  <= out_data;
            wen_q   <= wr_any;
            waddr_q <= wr_addr;
            wdata_q <= wr_data;
            for (int i = 0; i <= L; i++) stg[i] <= nxt[i];
        end
    end

    assign bus.rd_gnt_o      = rd_gnt;
    assign bus.wr_gnt_o      = wr_gnt;
    assign bus.rd_data_val_o = val_q;
    assign bus.rd_data_o     = data_q;
    assign bus.ram_rd_addr_o = stg[0].addr;
    assign bus.ram_wr_en_o   = wen_q;
    assign bus.ram_wr_addr_o = waddr_q;
    assign bus.ram_wr_data_o = wdata_q;
endmodule

// File: tb/tb_data_table_ram_arb.sv
// Bench for data_table_ram_arb: directed plan steps plus random traffic
// checked against a memory-level reference model.
module tb_data_table_ram_arb;
    logic clk;
    logic rst;
    logic ld;

    data_table_ram_arb_if #(.CLIENT_CNT(4), .A_WIDTH(8), .D_WIDTH(64)) bus ();
    data_table_ram_arb_if #(.CLIENT_CNT(4), .A_WIDTH(8), .D_WIDTH(64)) fbus ();

    data_table_ram_arb #(.CLIENT_CNT(4), .A_WIDTH(8), .D_WIDTH(64),
                         .RAM_LATENCY(2), .RR_MODE(1))
        dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    data_table_ram_arb #(.CLIENT_CNT(4), .A_WIDTH(8), .D_WIDTH(64),
                         .RAM_LATENCY(2), .RR_MODE(0))
        dut_fp (.clk_i(clk), .rst_i(rst), .bus(fbus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] init_val(input int a);
        if (a == 5)  return 64'hAA;
        if (a == 16) return 64'h11;
        return {32'hC0DE_0000, 24'h0, 8'(a)};
    endfunction

    // Read-first RAM, two cycles from address to data.
    logic [63:0] mem [0:255];
    logic [63:0] rpipe [0:1];
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else begin
            rpipe[0] <= mem[bus.ram_rd_addr_o];
            rpipe[1] <= rpipe[0];
            if (bus.ram_wr_en_o) mem[bus.ram_wr_addr_o] <= bus.ram_wr_data_o;
        end
    end
    assign bus.ram_rd_data_i  = rpipe[1];
    assign fbus.ram_rd_data_i = '0;

    int checks = 0;
    int errors = 0;
    int rptr, wptr, t;
    logic [63:0] ref_mem [0:255];
    logic        hv [0:4095];
    int          hid [0:4095];
    logic [7:0]  ha [0:4095];
    logic [3:0]  gr, gw, dut_rg, dut_wg, rq, wq, seen;

    task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] arb_ref(input logic [3:0] req, input int ptr);
        int c;
        for (int i = 0; i < 4; i++) begin
            c = (ptr + i) % 4;
            if (req[c]) return 4'(1 << c);
        end
        return 4'b0;
    endfunction

    function automatic int oh2i(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    // One cycle: check grants, apply the reference semantics, then check
    // the returned read. A read sees every write granted up to three
    // cycles after its own grant.
    task automatic tick();
        logic [3:0]  er, ew, nv;
        logic [63:0] nd;
        int          k;
        #1;
        er = arb_ref(bus.rd_req_i, rptr);
        ew = arb_ref(bus.wr_req_i, wptr);
        dut_rg = bus.rd_gnt_o;
        dut_wg = bus.wr_gnt_o;
        chk4("rd_gnt", dut_rg, er);
        chk4("wr_gnt", dut_wg, ew);
        if (ew != 0) begin
            k = oh2i(ew);
            ref_mem[bus.wr_addr_i[k*8 +: 8]] = bus.wr_data_i[k*64 +: 64];
            wptr = (k + 1) % 4;
        end
        hv[t] = 1'b0;
        if (er != 0) begin
            k = oh2i(er);
            hv[t]  = 1'b1;
            hid[t] = k;
            ha[t]  = bus.rd_addr_i[k*8 +: 8];
            rptr   = (k + 1) % 4;
        end
        nv = 4'b0;
        nd = '0;
        if (t >= 3 && hv[t-3]) begin
            nv = 4'(1 << hid[t-3]);
            nd = ref_mem[ha[t-3]];
        end
        gr = er;
        gw = ew;
        @(negedge clk);
        t++;
        chk4("rd_val", bus.rd_data_val_o, nv);
        if (nv != 0) chk64("rd_data", bus.rd_data_o, nd);
    endtask

    task automatic do_reset(input int n);
        bus.rd_req_i = '0;
        bus.wr_req_i = '0;
        rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            seen |= bus.rd_data_val_o;
            chk4("rst_val", bus.rd_data_val_o, 4'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4096; i++) hv[i] = 1'b0;
        rptr = 0;
        wptr = 0;
    endtask

    initial begin
        rst = 1'b1;
        ld  = 1'b1;
        t = 0; rptr = 0; wptr = 0;
        seen = '0;
        bus.rd_req_i = '0;  bus.rd_addr_i = '0;
        bus.wr_req_i = '0;  bus.wr_addr_i = '0;  bus.wr_data_i = '0;
        fbus.rd_req_i = '0; fbus.rd_addr_i = '0;
        fbus.wr_req_i = '0; fbus.wr_addr_i = '0; fbus.wr_data_i = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 4096; i++) hv[i] = 1'b0;
        @(negedge clk);
        ld = 1'b0;
        @(negedge clk);
        chk4("reset_val", bus.rd_data_val_o, 4'b0);
        chk4("reset_wen", 4'(bus.ram_wr_en_o), 4'b0);
        chk64("reset_raddr", 64'(bus.ram_rd_addr_o), 64'h0);
        rst = 1'b0;

        // Single read: client 2, addr 0x05.
        bus.rd_req_i = 4'b0100;
        bus.rd_addr_i[2*8 +: 8] = 8'h05;
        tick();
        chk4("single_gnt", dut_rg, 4'b0100);
        bus.rd_req_i = '0;
        repeat (3) tick();
        chk4("single_val", bus.rd_data_val_o, 4'b0100);
        chk64("single_data", bus.rd_data_o, 64'hAA);
        tick();
        chk4("single_idle", bus.rd_data_val_o, 4'b0);

        // Round-robin with all clients requesting.
        do_reset(2);
        for (int c = 0; c < 4; c++) bus.rd_addr_i[c*8 +: 8] = 8'(8'h30 + c);
        bus.rd_req_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk4("rr_seq", dut_rg, 4'(1 << (i % 4)));
        end
        bus.rd_req_i = '0;
        repeat (4) tick();

        // Fixed priority: client 0 wins every cycle.
        fbus.rd_req_i = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk4("fp_gnt", fbus.rd_gnt_o, 4'b0001);
        end
        chk4("fp_val", fbus.rd_data_val_o, 4'b0001);
        fbus.rd_req_i = '0;

        // Write-during-read forwarding at offsets 0..3.
        for (int off = 0; off < 4; off++) begin
            bus.wr_req_i = 4'b0001;
            bus.wr_addr_i[0 +: 8]  = 8'h10;
            bus.wr_data_i[0 +: 64] = 64'h11;
            tick();
            bus.wr_req_i = '0;
            repeat (2) tick();
            bus.rd_req_i = 4'b0010;
            bus.rd_addr_i[1*8 +: 8]   = 8'h10;
            bus.wr_addr_i[3*8 +: 8]   = 8'h10;
            bus.wr_data_i[3*64 +: 64] = 64'h99;
            for (int s = 0; s < 4; s++) begin
                bus.wr_req_i = (s == off) ? 4'b1000 : 4'b0000;
                tick();
                bus.rd_req_i = '0;
            end
            bus.wr_req_i = '0;
            chk4($sformatf("fwd_val_off%0d", off), bus.rd_data_val_o, 4'b0010);
            chk64($sformatf("fwd_data_off%0d", off), bus.rd_data_o, 64'h99);
            tick();
        end

        // Parallel read and write to different addresses.
        bus.wr_req_i = 4'b0001;
        bus.wr_addr_i[0 +: 8]  = 8'h20;
        bus.wr_data_i[0 +: 64] = 64'h55;
        bus.rd_req_i = 4'b0010;
        bus.rd_addr_i[1*8 +: 8] = 8'h21;
        tick();
        chk4("par_rgnt", dut_rg, 4'b0010);
        chk4("par_wgnt", dut_wg, 4'b0001);
        bus.wr_req_i = '0;
        bus.rd_req_i = '0;
        repeat (3) tick();
        chk64("par_rdata", bus.rd_data_o, init_val(8'h21));
        chk64("par_mem", mem[8'h20], 64'h55);

        // Reset mid-operation: three reads, then reset.
        for (int c = 0; c < 3; c++) bus.rd_addr_i[c*8 +: 8] = 8'(8'h40 + c);
        rq = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            bus.rd_req_i = rq;
            tick();
            rq &= ~gr;
        end
        seen = '0;
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= bus.rd_data_val_o;
        end
        chk4("rst_quiet", seen, 4'b0);
        bus.rd_req_i = 4'b1111;
        tick();
        chk4("rst_first_gnt", dut_rg, 4'b0001);
        bus.rd_req_i = '0;
        repeat (4) tick();

        // Random traffic on a small address window to force collisions.
        rq = '0;
        wq = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rq[c] && $urandom_range(1, 0) == 1) begin
                    rq[c] = 1'b1;
                    bus.rd_addr_i[c*8 +: 8] = 8'(8'h60 + $urandom_range(5, 0));
                end
                if (!wq[c] && $urandom_range(2, 0) == 0) begin
                    wq[c] = 1'b1;
                    bus.wr_addr_i[c*8 +: 8]   = 8'(8'h60 + $urandom_range(5, 0));
                    bus.wr_data_i[c*64 +: 64] = {$urandom(), $urandom()};
                end
            end
            bus.rd_req_i = rq;
            bus.wr_req_i = wq;
            tick();
            rq &= ~gr;
            wq &= ~gw;
        end
        bus.rd_req_i = '0;
        bus.wr_req_i = '0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
